// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for an in-order pipeline: tracks in-flight destinations
// from EX to WB. It raises stall on unresolved RAW hazards and steers operand forwarding.
module hazard_scoreboard #(
    parameter int REG_AW = 3,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic              issue_load,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              src1_used,
    input  logic              src2_used,
    input  logic              flush,
    output logic              stall,
    output logic [FW-1:0]     fwd_sel1,
    output logic [FW-1:0]     fwd_sel2,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  load_pipe;
    logic [REG_AW-1:0] dest_pipe [DEPTH];

    logic [DEPTH-1:0]  match1;
    logic [DEPTH-1:0]  match2;
    logic              any_hit;
    logic              load_use;
    logic              issue_fire;
    logic [FW-1:0]     sel1_raw;
    logic [FW-1:0]     sel2_raw;

    // Lowest matching index is the youngest producer, so it wins.
    function automatic logic [FW-1:0] youngest(input logic [DEPTH-1:0] m);
        logic [FW-1:0] sel;
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m[i]) sel = FW'(i + 1);
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Source-versus-entry compare (combinational on live decode inputs)
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = src1_used && (src1 != '0) && vld[i] && (dest_pipe[i] == src1);
            match2[i] = src2_used && (src2 != '0) && vld[i] && (dest_pipe[i] == src2);
        end
    end

    always_comb begin
        any_hit  = (|match1) || (|match2);
        load_use = (match1[0] || match2[0]) && load_pipe[0];
        sel1_raw = youngest(match1);
        sel2_raw = youngest(match2);
        stall    = 1'b0;
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        if (issue_valid && !flush) begin
            stall = (FWD_EN != 0) ? load_use : any_hit;
        end
        if (FWD_EN != 0) begin
            fwd_sel1 = sel1_raw;
            fwd_sel2 = sel2_raw;
        end
    end

    assign issue_fire = issue_valid && issue_wr && !stall && !flush && (issue_dest != '0);

    // Tracking pipe control: entry 0 = EX, entry DEPTH-1 = WB
    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                vld[i] <= vld[i-1];
            end
            vld[0] <= issue_fire;
            if (stall) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // Tracking pipe data: only meaningful where vld is set
    always_ff @(posedge clk) begin
        for (int i = DEPTH - 1; i >= 1; i--) begin
            dest_pipe[i] <= dest_pipe[i-1];
            load_pipe[i] <= load_pipe[i-1];
        end
        dest_pipe[0] <= issue_dest;
        load_pipe[0] <= issue_load;
    end

endmodule
